// File: rtl/pwm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_pkg : shared types and helpers for the PWM sample path          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STARVE = 2'd2
  } pwm_feed_st_t;

  function automatic int unsigned pwm_sat(input int unsigned value, input int unsigned cce);
    return (value > cce) ? cce : value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_feed_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_feed_if : sample input stream and PWM-side duty stream          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface pwm_feed_if #(
  parameter int CCW = 4
);
  logic [CCW-1:0] sti_dat;
  logic           sti_vld;
  logic           sti_rdy;
  logic [CCW-1:0] str_dat;
  logic           str_rdy;

  modport master (
    output sti_dat, sti_vld, str_rdy,
    input  sti_rdy, str_dat
  );

  modport slave (
    input  sti_dat, sti_vld, str_rdy,
    output sti_rdy, str_dat
  );
endinterface
`default_nettype wire

// File: rtl/pwm_feed_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_feed_fifo : single-clock FIFO with level, no fall-through       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module pwm_feed_fifo #(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdat_i,
  output logic [DW-1:0] rdat_o,
  output logic [AW:0]   lvl_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int unsigned DEPTH = 2**AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   lvl_q;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (lvl_q == (AW+1)'(DEPTH));
  assign empty_o = (lvl_q == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign rdat_o  = mem_q[rptr_q];
  assign lvl_o   = lvl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lvl_q  <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + AW'(1);
      if (w_pop)  rptr_q <= rptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   lvl_q <= lvl_q + (AW+1)'(1);
        2'b01:   lvl_q <= lvl_q - (AW+1)'(1);
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  // Storage is left unreset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q] <= wdat_i;
  end
endmodule
`default_nettype wire

// File: rtl/pwm_feed.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_feed : buffers duty samples and steps them out per PWM period   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module pwm_feed
  import pwm_pkg::*;
#(
  parameter int CCW = 4,
  parameter int CCE = 2**CCW-1,
  parameter int AW  = 4,
  parameter int RW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_ena,
  input  logic [RW-1:0] cfg_rpt,
  input  logic          sts_clr,
  pwm_feed_if.slave     bus,
  output logic [AW:0]   sts_lvl,
  output logic          sts_unf
);
  pwm_feed_st_t   state_q, state_d;
  logic [RW-1:0]  rpt_q,   rpt_d;
  logic [CCW-1:0] dat_q,   dat_d;
  logic           unf_q,   unf_d;

  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_unf_set;
  logic [CCW-1:0] w_head;
  logic [CCW-1:0] w_wdat;

  assign w_wdat      = CCW'(pwm_sat(32'(bus.sti_dat), CCE));
  assign bus.sti_rdy = ~w_full & ~rst;
  assign w_push      = bus.sti_vld & bus.sti_rdy;

  pwm_feed_fifo #(
    .DW (CCW),
    .AW (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdat_i  (w_wdat),
    .rdat_o  (w_head),
    .lvl_o   (sts_lvl),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rpt_q   <= '0;
      dat_q   <= '0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rpt_q   <= rpt_d;
      dat_q   <= dat_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rpt_d     = rpt_q;
    dat_d     = dat_q;
    w_pop     = 1'b0;
    w_unf_set = 1'b0;
    if (!cfg_ena) begin
      state_d = IDLE;
      rpt_d   = '0;
      dat_d   = '0;
    end else begin
      case (state_q)
        // Preloading the counter makes the very first period boundary a load.
        IDLE: begin
          state_d = RUN;
          rpt_d   = cfg_rpt;
          dat_d   = '0;
        end
        RUN: begin
          if (bus.str_rdy) begin
            if (rpt_q >= cfg_rpt) begin
              if (!w_empty) begin
                w_pop = 1'b1;
                dat_d = w_head;
                rpt_d = '0;
              end else begin
                state_d   = STARVE;
                w_unf_set = 1'b1;
              end
            end else begin
              rpt_d = rpt_q + RW'(1);
            end
          end
        end
        STARVE: begin
          if (bus.str_rdy) begin
            if (!w_empty) begin
              w_pop   = 1'b1;
              dat_d   = w_head;
              rpt_d   = '0;
              state_d = RUN;
            end else begin
              w_unf_set = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    unf_d = w_unf_set | (unf_q & ~sts_clr);
  end

  assign bus.str_dat = dat_q;
  assign sts_unf     = unf_q;
endmodule
`default_nettype wire

// File: tb/tb_pwm_feed.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pwm_feed : directed and random checks of pwm_feed (CCE 15 / 12)  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_pwm_feed;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_ena = 1'b0;
  logic [7:0] cfg_rpt = 8'd0;
  logic       sts_clr = 1'b0;
  logic [3:0] sti_dat = 4'd0;
  logic       sti_vld = 1'b0;
  logic       str_rdy = 1'b0;
  logic [4:0] lvl0, lvl1;
  logic       unf0, unf1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pwm_feed_if #(.CCW(4)) bus0 ();
  pwm_feed_if #(.CCW(4)) bus1 ();

  assign bus0.sti_dat = sti_dat;
  assign bus0.sti_vld = sti_vld;
  assign bus0.str_rdy = str_rdy;
  assign bus1.sti_dat = sti_dat;
  assign bus1.sti_vld = sti_vld;
  assign bus1.str_rdy = str_rdy;

  pwm_feed #(.CCW(4), .CCE(15), .AW(4), .RW(8)) u_dut0 (
    .clk(clk), .rst(rst), .cfg_ena(cfg_ena), .cfg_rpt(cfg_rpt), .sts_clr(sts_clr),
    .bus(bus0.slave), .sts_lvl(lvl0), .sts_unf(unf0)
  );

  pwm_feed #(.CCW(4), .CCE(12), .AW(4), .RW(8)) u_dut1 (
    .clk(clk), .rst(rst), .cfg_ena(cfg_ena), .cfg_rpt(cfg_rpt), .sts_clr(sts_clr),
    .bus(bus1.slave), .sts_lvl(lvl1), .sts_unf(unf1)
  );

  // Reference: a queue of stored samples, the value the PWM currently sees,
  // and how many period boundaries that value has already been consumed on.
  int mq [2][$];
  int m_cur  [2];
  int m_cnt  [2];
  bit m_must [2];
  bit m_run  [2];
  bit m_unf  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int cce;
      bit set;
      bit acc;
      cce = (k == 0) ? 15 : 12;
      if (rst) begin
        mq[k].delete();
        m_cur[k] = 0; m_cnt[k] = 0; m_must[k] = 0; m_run[k] = 0; m_unf[k] = 0;
      end else begin
        acc = sti_vld && (mq[k].size() < DEPTH);
        set = 0;
        if (!cfg_ena) begin
          m_run[k] = 0;
          m_cur[k] = 0;
        end else if (!m_run[k]) begin
          m_run[k] = 1; m_cur[k] = 0; m_must[k] = 1; m_cnt[k] = 0;
        end else if (str_rdy) begin
          m_cnt[k]++;
          if (m_must[k] || m_cnt[k] >= int'(cfg_rpt) + 1) begin
            if (mq[k].size() > 0) begin
              m_cur[k]  = mq[k].pop_front();
              m_cnt[k]  = 0;
              m_must[k] = 0;
            end else begin
              set       = 1;
              m_must[k] = 1;
            end
          end
        end
        m_unf[k] = set | (m_unf[k] & ~sts_clr);
        if (acc) mq[k].push_back((int'(sti_dat) > cce) ? cce : int'(sti_dat));
      end
    end
  endtask

  task automatic compare();
    chk("dat0", 32'(bus0.str_dat), m_cur[0]);
    chk("lvl0", 32'(lvl0), mq[0].size());
    chk("unf0", 32'(unf0), 32'(m_unf[0]));
    chk("rdy0", 32'(bus0.sti_rdy), 32'(!rst && mq[0].size() < DEPTH));
    chk("dat1", 32'(bus1.str_dat), m_cur[1]);
    chk("lvl1", 32'(lvl1), mq[1].size());
    chk("unf1", 32'(unf1), 32'(m_unf[1]));
    chk("rdy1", 32'(bus1.sti_rdy), 32'(!rst && mq[1].size() < DEPTH));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input int v);
    sti_vld = 1'b1;
    sti_dat = 4'(v);
    tick();
    sti_vld = 1'b0;
  endtask

  task automatic pulse(output int consumed);
    str_rdy  = 1'b1;
    consumed = int'(bus0.str_dat);
    tick();
    str_rdy  = 1'b0;
  endtask

  initial begin
    int seq1 [5];
    int seq2 [7];
    int got;
    seq1 = '{0, 1, 2, 3, 3};
    seq2 = '{0, 5, 5, 5, 9, 9, 9};
    for (int k = 0; k < 2; k++) begin
      m_cur[k] = 0; m_cnt[k] = 0; m_must[k] = 0; m_run[k] = 0; m_unf[k] = 0;
    end

    idle(3);
    rst = 1'b0;
    idle(2);

    // One period per sample, pulse every 16 cycles.
    push(1); push(2); push(3);
    cfg_ena = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      idle(15);
      pulse(got);
      chk($sformatf("seq1[%0d]", i), got, seq1[i]);
    end
    chk("seq1_unf", 32'(unf0), 1);
    cfg_ena = 1'b0; tick();
    sts_clr = 1'b1; tick(); sts_clr = 1'b0;

    // Each sample held for three periods.
    cfg_rpt = 8'd2;
    push(5); push(9);
    cfg_ena = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      idle(3);
      pulse(got);
      chk($sformatf("seq2[%0d]", i), got, seq2[i]);
    end
    cfg_ena = 1'b0; tick();
    sts_clr = 1'b1; tick(); sts_clr = 1'b0;

    // Fill past capacity, then pop/push interactions at the full boundary.
    for (int i = 0; i < 17; i++) push(i);
    chk("full_lvl", 32'(lvl0), 16);
    chk("full_rdy", 32'(bus0.sti_rdy), 0);
    cfg_rpt = 8'd0;
    cfg_ena = 1'b1; tick();
    pulse(got);
    chk("pop_lvl", 32'(lvl0), 15);
    push(4);
    chk("refill_lvl", 32'(lvl0), 16);
    sti_vld = 1'b1; sti_dat = 4'd6;
    pulse(got);
    chk("full_pushpop", 32'(lvl0), 15);
    pulse(got);
    sti_vld = 1'b0;
    chk("pushpop_lvl", 32'(lvl0), 15);
    cfg_ena = 1'b0; tick();

    // Clamp above CCE.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    cfg_ena = 1'b1; tick();
    push(15);
    pulse(got);
    chk("clamp15", 32'(bus0.str_dat), 15);
    chk("clamp12", 32'(bus1.str_dat), 12);

    // Starvation, recovery, and flag clear priority.
    pulse(got);
    chk("starve_unf", 32'(unf0), 1);
    push(7);
    pulse(got);
    chk("recover_dat", 32'(bus0.str_dat), 7);
    sts_clr = 1'b1;
    pulse(got);
    sts_clr = 1'b0;
    chk("clr_vs_set", 32'(unf0), 1);
    sts_clr = 1'b1; tick(); sts_clr = 1'b0;
    chk("clr_alone", 32'(unf0), 0);

    // Enable drop keeps the FIFO; reset flushes it.
    cfg_rpt = 8'd3;
    for (int i = 3; i <= 8; i++) push(i);
    pulse(got);
    chk("drop_pre_dat", 32'(bus0.str_dat), 3);
    pulse(got);
    cfg_ena = 1'b0; tick();
    chk("drop_dat", 32'(bus0.str_dat), 0);
    chk("drop_lvl", 32'(lvl0), 5);
    cfg_ena = 1'b1; tick();
    pulse(got);
    push(9);
    chk("pre_rst_dat", 32'(bus0.str_dat), 4);
    chk("pre_rst_lvl", 32'(lvl0), 5);
    rst = 1'b1; tick();
    chk("rst_dat", 32'(bus0.str_dat), 0);
    chk("rst_lvl", 32'(lvl0), 0);
    chk("rst_unf", 32'(unf0), 0);
    rst = 1'b0; tick();

    // Random traffic against the reference.
    for (int i = 0; i < 4000; i++) begin
      sti_vld = ($urandom_range(0, 1) == 1);
      sti_dat = 4'($urandom_range(0, 15));
      str_rdy = ($urandom_range(0, 5) == 0);
      sts_clr = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 149) == 0) begin
        cfg_ena = ~cfg_ena;
        if (!cfg_ena) cfg_rpt = 8'($urandom_range(0, 3));
      end
      tick();
    end
    sti_vld = 1'b0; str_rdy = 1'b0; sts_clr = 1'b0; rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
